cell_particle_reader: RTL and testbench
=======================================

Name: cell_particle_reader

Overview:
- Read-side initiator for one cell position memory (single-port M20K, 96-bit word {posz, posy, posx}).
- Streams particles 0..count-1 of one cell to the force-evaluation pipeline over a valid/ready interface.
- Hides the RAM read latency with a credit-limited output FIFO, so downstream backpressure never loses or duplicates a particle.
- Instantiated once per cell memory inside RL_LJ_Top, between the cell memory and the filter/force units.

Parameters:
- DATA_WIDTH, 96, RAM word width {posz, posy, posx}, 32 bits each.
- PARTICLE_NUM, 220, max particles per cell; equals the cell memory depth.
- ADDR_WIDTH, 8, RAM address width; must satisfy 2^ADDR_WIDTH >= PARTICLE_NUM.
- RD_LATENCY, 1, cycles from rden/address to valid RAM q.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_LATENCY+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begin streaming the cell.
- particle_count  in  ADDR_WIDTH+1  number of particles to stream; sampled when start is accepted.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last particle is handed off.
- mem_address  out  ADDR_WIDTH  to cell memory address.
- mem_rden  out  1  to cell memory rden.
- mem_wren  out  1  to cell memory wren; constant 0.
- mem_q  in  DATA_WIDTH  from cell memory q.
- out_data  out  DATA_WIDTH  particle position {posz, posy, posx}.
- out_id  out  ADDR_WIDTH  particle index within the cell.
- out_last  out  1  high with the final particle.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat when out_valid & out_ready.

Behaviour:
Reset values:
- When rst is sampled high: all outputs 0, FSM in IDLE, FIFO empty, counters and in-flight shift register cleared.
- Reset mid-operation abandons the stream. Reads still in flight are discarded, and no done pulse is produced.

FSM states:
- IDLE: start=1 latches cnt=particle_count, sets rd_ptr=0, asserts busy, and goes to RUN. If particle_count=0, it goes to FIN instead.
- RUN: issues reads. After read cnt-1 has been issued, it goes to DRAIN.
- DRAIN: waits until there are no reads in flight, the FIFO is empty and the last beat has been accepted, then goes to FIN.
- FIN: done=1 for one cycle, busy=0, then returns to IDLE.

Start handling:
- start in any state other than IDLE is ignored.
- particle_count > PARTICLE_NUM is clamped to PARTICLE_NUM.

Read issue:
- In RUN, mem_rden=1 and mem_address=rd_ptr when (inflight + fifo_level) < FIFO_DEPTH.
- rd_ptr increments on each issued read.
- mem_rden=0 otherwise.

Read return:
- A RD_LATENCY-deep shift register tags each issued read with its id and a last flag (id == cnt-1).
- When a tagged entry emerges, mem_q, id and last are pushed into the FIFO in the same cycle.
- The credit rule guarantees that a push never hits a full FIFO. Overflow is an assertion failure.

Output:
- The FIFO head drives out_data, out_id and out_last; out_valid = !fifo_empty.
- A pop happens on out_valid & out_ready.
- Push and pop in the same cycle leave fifo_level unchanged.
- Outputs are held stable while out_valid=1 and out_ready=0.

Throughput and latency:
- With out_ready held at 1: one beat per cycle after the initial RD_LATENCY+1 cycles (start -> first out_valid = RD_LATENCY+1 cycles).
- done follows the final handshake by exactly 1 cycle.
- Particle ids are emitted strictly in order 0..cnt-1, with no gaps or repeats.

Decomposition:
- define.v holds the shared constants PARTICLE_NUM, ADDR_WIDTH, DATA_WIDTH and the field offsets of posx/posy/posz.
- One sub-module: cell_reader_fifo, a synchronous FIFO of width DATA_WIDTH+ADDR_WIDTH+1 and depth FIFO_DEPTH.
  - Ports: push, pop, din, dout, empty, level.
  - It has a show-ahead head and supports simultaneous push and pop.

Test Plan:
1. Reset, then start with particle_count=220 and out_ready=1 -> ids 0..219 in order, a beat every cycle from cycle 2 after start, out_last on id 219, done 1 cycle after that beat, data matching the cell init file.
2. particle_count=5 with out_ready toggling 1,0,0,1 repeatedly -> exactly 5 beats, ids 0..4, outputs stable during stalls, no FIFO overflow, mem_rden stops when credits are exhausted.
3. particle_count=0 -> no out_valid and no mem_rden, busy for 1 cycle, done pulse 1 cycle after start.
4. start pulsed again at cycle 10 of a 50-particle run -> second start ignored, exactly 50 beats, a single done.
5. rst asserted mid-stream at id 17 with a read in flight -> the next cycle has all outputs 0, the FIFO is empty, and no stale beat appears; a fresh start with count 3 then streams ids 0..2 correctly.
6. out_ready=0 for 20 cycles after start with count 10 -> exactly FIFO_DEPTH reads issued (4), then stall; on out_ready=1, all 10 beats complete in order.

Source files
------------

// File: rtl/cell_particle_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cell_particle_reader_pkg
//  Description : Shared constants, position field offsets and the FSM state
//                type for the cell particle reader.
//  Revision    : 1.0 - initial release
// ============================================================================
package cell_particle_reader_pkg;

  // Default geometry of one cell position memory.
  localparam int DEF_DATA_WIDTH   = 96;
  localparam int DEF_PARTICLE_NUM = 220;
  localparam int DEF_ADDR_WIDTH   = 8;
  localparam int DEF_RD_LATENCY   = 1;
  localparam int DEF_FIFO_DEPTH   = 4;

  // Field layout of a RAM word {posz, posy, posx}.
  localparam int POS_WIDTH = 32;
  localparam int POSX_LSB  = 0;
  localparam int POSY_LSB  = 32;
  localparam int POSZ_LSB  = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cell_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cell_reader_fifo
//  Description : Synchronous show-ahead FIFO. The head entry is visible on
//                dout whenever empty=0; push and pop may occur together.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                push/din  - write an entry
//                pop       - drop the head entry (ignored when empty)
//                dout      - head entry
//                empty     - no entries stored
//                level     - number of entries stored
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_reader_fifo #(
  parameter  int WIDTH = 105,
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_pop;

  // Pointer wrap that also works for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop   = pop && (level_q != '0);
    wr_ptr_d = push   ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    if (push && !do_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push && do_pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset: it is only observed through the level counter.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // The upstream credit scheme must never push into a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !do_pop && (level_q == LVL_W'(DEPTH))));
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule
`default_nettype wire

// File: rtl/cell_particle_reader.sv
`default_nettype none
// ============================================================================
//  Module      : cell_particle_reader
//  Description : Streams particles 0..count-1 of one cell position memory to
//                a valid/ready consumer. Reads are credit-limited against an
//                output FIFO so backpressure never drops or repeats a beat.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start              - pulse, begin streaming (IDLE only)
//                particle_count     - particles to stream, sampled on start
//                busy, done         - run status / completion pulse
//                mem_address/rden/wren, mem_q - cell memory read port
//                out_data/id/last/valid, out_ready - particle stream
//  Revision    : 1.0 - initial release
// ============================================================================
module cell_particle_reader
  import cell_particle_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PARTICLE_NUM = DEF_PARTICLE_NUM,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int RD_LATENCY   = DEF_RD_LATENCY,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   particle_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_id,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W   = ADDR_WIDTH + 1;
  localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W   = $clog2(FIFO_DEPTH + RD_LATENCY + 1);

  state_e                                  state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]                   rd_ptr_q, rd_ptr_d;
  logic [RD_LATENCY-1:0]                   sr_vld_q, sr_vld_d;
  logic [RD_LATENCY-1:0]                   sr_last_q, sr_last_d;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]   sr_id_q, sr_id_d;

  logic [CNT_W-1:0]      count_clamped;
  logic [CRD_W-1:0]      inflight;
  logic                  credit_ok;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_id;
  logic                  issue_last;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [LVL_W-1:0]      fifo_level;
  logic [ENTRY_W-1:0]    fifo_dout;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_id;
  logic                  head_last;

  assign count_clamped = (particle_count > CNT_W'(PARTICLE_NUM)) ?
                         CNT_W'(PARTICLE_NUM) : particle_count;

  // Reads already issued whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CRD_W'(sr_vld_q[i]);
    end
  end

  // A read may be issued only if its data is guaranteed a FIFO slot.
  assign credit_ok = (inflight + CRD_W'(fifo_level)) < CRD_W'(FIFO_DEPTH);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    issue      = 1'b0;
    issue_id   = '0;
    issue_last = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy  = 1'b1;
          cnt_d = count_clamped;
          if (count_clamped == '0) begin
            state_d = ST_FIN;
          end else begin
            // Read 0 goes out in the start cycle itself (FIFO and pipeline
            // are empty in IDLE) so the first beat is valid RD_LATENCY+1
            // cycles after start; rd_ptr therefore resumes at 1.
            issue      = 1'b1;
            issue_last = (count_clamped == CNT_W'(1));
            rd_ptr_d   = ADDR_WIDTH'(1);
            state_d    = issue_last ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (credit_ok) begin
          issue      = 1'b1;
          issue_id   = rd_ptr_q;
          issue_last = ({1'b0, rd_ptr_q} == (cnt_q - CNT_W'(1)));
          rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
          if (issue_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave as the last beat is accepted so done trails it by one cycle.
        if (fifo_pop && head_last && (inflight == '0)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tag pipeline aligned with the RAM read latency; stage RD_LATENCY-1
  // coincides with valid mem_q.
  always_comb begin
    sr_vld_d     = sr_vld_q;
    sr_last_d    = sr_last_q;
    sr_id_d      = sr_id_q;
    sr_vld_d[0]  = issue;
    sr_last_d[0] = issue_last;
    sr_id_d[0]   = issue_id;
    for (int i = 1; i < RD_LATENCY; i++) begin
      sr_vld_d[i]  = sr_vld_q[i-1];
      sr_last_d[i] = sr_last_q[i-1];
      sr_id_d[i]   = sr_id_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_ptr_q  <= '0;
      sr_vld_q  <= '0;
      sr_last_q <= '0;
      sr_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_ptr_q  <= rd_ptr_d;
      sr_vld_q  <= sr_vld_d;
      sr_last_q <= sr_last_d;
      sr_id_q   <= sr_id_d;
    end
  end

  cell_reader_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sr_vld_q[RD_LATENCY-1]),
    .pop   (fifo_pop),
    .din   ({sr_last_q[RD_LATENCY-1], sr_id_q[RD_LATENCY-1], mem_q}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign {head_last, head_id, head_data} = fifo_dout;
  assign fifo_pop = out_valid && out_ready;

  // Beat fields are forced to zero while empty so stale storage never leaks.
  assign out_valid   = !fifo_empty;
  assign out_data    = out_valid ? head_data : '0;
  assign out_id      = out_valid ? head_id   : '0;
  assign out_last    = out_valid && head_last;
  assign mem_rden    = issue;
  assign mem_address = issue_id;
  assign mem_wren    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_cell_particle_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cell_particle_reader
//  Description : Self-checking bench for cell_particle_reader with a RAM
//                model and a queue-based reference of the expected stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cell_particle_reader;

  localparam int PNUM  = 220;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [95:0] data;
    logic [7:0]  id;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  particle_count = '0;
  logic        busy, done;
  logic [7:0]  mem_address;
  logic        mem_rden, mem_wren;
  logic [95:0] mem_q = '0;
  logic [95:0] out_data;
  logic [7:0]  out_id;
  logic        out_last, out_valid;
  logic        out_ready = 1'b1;

  cell_particle_reader dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .particle_count (particle_count),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .out_data       (out_data),
    .out_id         (out_id),
    .out_last       (out_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  always #5 clk = ~clk;

  // Cell memory model, one cycle read latency.
  logic [95:0] ram [PNUM];
  always @(posedge clk) begin
    if (mem_rden) mem_q <= ram[mem_address];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  beat_t exp_q[$];
  bit    en = 1'b0;
  bit    rst_prev = 1'b0;
  bit    active = 1'b0;
  bit    done_due = 1'b0;
  bit    want_first = 1'b0;
  int    next_rd = 0;
  int    outstanding = 0;
  int    model_cnt = 0;
  int    beat_cnt = 0;
  int    done_cnt = 0;
  int    rd_cnt = 0;
  int    start_cyc = 0;
  int    done_cyc = 0;
  int    first_cyc = 0;
  bit          pv_valid = 1'b0, pv_ready = 1'b0;
  logic [95:0] pv_data;
  logic [7:0]  pv_id;
  logic        pv_last;

  always @(negedge clk) begin
    bit    exp_done;
    beat_t b;
    if (en) begin
      if (rst_prev) begin
        chk("rst_outputs_zero",
            {10'd0, out_valid, busy, done, mem_rden, mem_wren, out_last, out_id, mem_address, out_data},
            128'd0);
      end
      chk("mem_wren_zero", mem_wren, 0);

      exp_done = done_due;
      done_due = 1'b0;
      chk("done", done, exp_done);
      chk("busy", busy, (active && !exp_done) || (!active && start));
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (exp_done) active = 1'b0;

      if (!active && start && !rst) begin
        active      = 1'b1;
        model_cnt   = (particle_count > PNUM) ? PNUM : int'(particle_count);
        start_cyc   = cyc;
        want_first  = 1'b1;
        next_rd     = 0;
        outstanding = 0;
        for (int i = 0; i < model_cnt; i++) begin
          b.data = ram[i]; b.id = 8'(i); b.last = (i == model_cnt - 1);
          exp_q.push_back(b);
        end
        if (model_cnt == 0) done_due = 1'b1;
      end

      if (mem_rden) begin
        chk("rd_address", mem_address, (next_rd < model_cnt) ? next_rd : 999);
        chk("rd_credit", outstanding < DEPTH, 1);
        next_rd++; outstanding++; rd_cnt++;
      end

      chk("no_spurious_valid", out_valid && (exp_q.size() == 0), 0);
      if (pv_valid && !pv_ready && !rst_prev) begin
        chk("stall_hold", {out_valid, out_last, out_id, out_data},
            {1'b1, pv_last, pv_id, pv_data});
      end
      if (out_valid && want_first) begin first_cyc = cyc; want_first = 1'b0; end

      if (out_valid && out_ready && exp_q.size() != 0) begin
        b = exp_q.pop_front();
        chk("beat", {out_last, out_id, out_data}, {b.last, b.id, b.data});
        beat_cnt++; outstanding--;
        if (b.last) done_due = 1'b1;
      end

      pv_valid = out_valid; pv_ready = out_ready;
      pv_data = out_data; pv_id = out_id; pv_last = out_last;
      if (rst) begin
        exp_q.delete();
        active = 1'b0; done_due = 1'b0; want_first = 1'b0;
        outstanding = 0; pv_valid = 1'b0;
      end
    end
    rst_prev = rst;
  end

  // ---------------- stimulus ----------------
  function automatic logic ready_fn(input int mode, input int rc, input int hold);
    case (mode)
      0: return 1'b1;
      1: return (rc % 4 == 0) || (rc % 4 == 3);
      2: return 1'(($urandom_range(0, 3)) != 0);
      default: return rc >= hold;
    endcase
  endfunction

  // One run: start at rc=0, optional second start at restart_at, ends on done.
  task automatic run(input int count, input int mode, input int hold, input int restart_at,
                     output int reads_at_hold);
    int d0, r0, rc;
    d0 = done_cnt; r0 = rd_cnt; rc = 0; reads_at_hold = -1;
    while (done_cnt == d0 && rc < 3000) begin
      @(posedge clk); #1;
      if (rc == hold) reads_at_hold = rd_cnt - r0;
      start          = (rc == 0) || (rc == restart_at);
      particle_count = (rc == 0) ? 9'(count) : 9'd7;
      out_ready      = ready_fn(mode, rc, hold);
      rc++;
    end
    if (done_cnt == d0) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: got no done expected done (count %0d)", count);
    end
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int b0, d0, rh, cnt, mode;
    for (int i = 0; i < PNUM; i++) ram[i] = {$urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // 1: full cell, no backpressure
    b0 = beat_cnt; d0 = done_cnt;
    run(220, 0, 0, -1, rh);
    chk("t1_beats", beat_cnt - b0, 220);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_first_latency", first_cyc - start_cyc, 2);
    chk("t1_done_latency", done_cyc - start_cyc, 222);

    // 2: ready pattern 1,0,0,1
    b0 = beat_cnt; d0 = done_cnt;
    run(5, 1, 0, -1, rh);
    chk("t2_beats", beat_cnt - b0, 5);
    chk("t2_done_count", done_cnt - d0, 1);

    // 3: empty cell
    b0 = beat_cnt; d0 = rd_cnt;
    run(0, 0, 0, -1, rh);
    chk("t3_beats", beat_cnt - b0, 0);
    chk("t3_reads", rd_cnt - d0, 0);
    chk("t3_done_latency", done_cyc - start_cyc, 1);

    // 4: second start ignored
    b0 = beat_cnt; d0 = done_cnt;
    run(50, 0, 0, 10, rh);
    chk("t4_beats", beat_cnt - b0, 50);
    chk("t4_done_count", done_cnt - d0, 1);

    // 5: reset mid-stream at id 17, then a fresh short run
    @(posedge clk); #1; start = 1'b1; particle_count = 9'd40; out_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_id == 8'd17) break;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt;
    repeat (6) @(posedge clk);
    chk("t5_no_done_after_reset", done_cnt - d0, 0);
    b0 = beat_cnt;
    run(3, 0, 0, -1, rh);
    chk("t5_fresh_beats", beat_cnt - b0, 3);

    // 6: long initial stall
    b0 = beat_cnt;
    run(10, 3, 20, -1, rh);
    chk("t6_reads_during_stall", rh, DEPTH);
    chk("t6_beats", beat_cnt - b0, 10);

    // 7: random counts (including clamped ones) with random backpressure
    for (int k = 0; k < 6; k++) begin
      cnt  = $urandom_range(0, 300);
      mode = $urandom_range(0, 2);
      b0 = beat_cnt; d0 = done_cnt;
      run(cnt, mode, 0, -1, rh);
      chk("t7_beats", beat_cnt - b0, (cnt > PNUM) ? PNUM : cnt);
      chk("t7_done_count", done_cnt - d0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
